// File: rtl/spike_window_capture_if.sv
// -----------------------------------------------------------------------------
// spike_window_capture_if
// Frame output bus of the spike window capture front end.
//   spike_vec   : captured frame, bit t = spike seen in slot t
//   first_time  : lowest slot index holding a spike (0 when empty)
//   spike_count : number of spikes in the frame
//   no_spike    : frame holds no spike
//   out_valid   : frame fields are valid and stable
//   out_ready   : consumer accepts the frame
// Modports: master = producer (capture block), slave = consumer.
// -----------------------------------------------------------------------------
interface spike_window_capture_if #(
    parameter int LEN = 8,
    parameter int TW  = $clog2(LEN),
    parameter int CW  = $clog2(LEN + 1)
);
    logic [0:LEN-1] spike_vec;
    logic [TW-1:0]  first_time;
    logic [CW-1:0]  spike_count;
    logic           no_spike;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output spike_vec, first_time, spike_count, no_spike, out_valid,
        input  out_ready
    );

    modport slave (
        input  spike_vec, first_time, spike_count, no_spike, out_valid,
        output out_ready
    );
endinterface

// File: rtl/spike_window_capture.sv
// -----------------------------------------------------------------------------
// spike_window_capture
// Samples a serial spike line over a window of LEN cycles, assembles the
// slot-indexed spike vector and reports first-spike time and spike count.
// A completed frame is held on a valid/ready handshake.
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   frame_start : slot 0 of a new window (spike_in sampled same cycle)
//   spike_in    : serial spike line
//   busy        : capture in progress
//   overrun     : one-cycle pulse after a dropped frame_start
//   bus         : frame output bus (spike_window_capture_if.master)
//
// Build option: define FIRST_SPIKE_ONLY_EN to keep only the first spike of a
// frame (spike_vec one-hot or zero, spike_count 0 or 1).
// -----------------------------------------------------------------------------
module spike_window_capture #(
    parameter int LEN = 8,
    parameter int TW  = $clog2(LEN),
    parameter int CW  = $clog2(LEN + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start,
    input  logic                          spike_in,
    output logic                          busy,
    output logic                          overrun,
    spike_window_capture_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [TW-1:0]  r_slot;
    logic [0:LEN-1] r_acc;
    logic [0:LEN-1] r_spike_vec;
    logic [TW-1:0]  r_first_time;
    logic [CW-1:0]  r_spike_count;
    logic           r_no_spike;
    logic           r_overrun;

    logic           w_start;
    logic           w_sample;
    logic           w_load;
    logic           w_overrun;
    logic           w_keep;
    logic [0:LEN-1] w_final;

    // Lowest set slot index; 0 for an empty frame.
    function automatic logic [TW-1:0] first_index(input logic [0:LEN-1] vec);
        logic [TW-1:0] idx;
        idx = '0;
        for (int i = LEN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = TW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Number of set slots; CW is wide enough to hold LEN.
    function automatic logic [CW-1:0] pop_count(input logic [0:LEN-1] vec);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < LEN; i++) begin
            cnt = cnt + CW'(vec[i]);
        end
        return cnt;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_sample     = 1'b0;
        w_load       = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_start) begin
                    w_start      = 1'b1;
                    w_state_next = CAPTURE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            CAPTURE: begin
                w_sample  = 1'b1;
                w_overrun = frame_start;
                if (r_slot == TW'(LEN - 1)) begin
                    w_load       = 1'b1;
                    w_state_next = HOLD;
                end else begin
                    w_state_next = CAPTURE;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    // Accept and optionally start the next frame with no bubble.
                    if (frame_start) begin
                        w_start      = 1'b1;
                        w_state_next = CAPTURE;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_overrun    = frame_start;
                    w_state_next = HOLD;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Spike acceptance for the current capture slot.
    always_comb begin
`ifdef FIRST_SPIKE_ONLY_EN
        // Accumulator was cleared at frame start, so any set bit is this frame's.
        w_keep = spike_in & ~(|r_acc);
`else
        w_keep = spike_in;
`endif
    end

    // Accumulator value including the slot sampled this cycle.
    always_comb begin
        w_final = r_acc;
        if (w_sample) begin
            w_final[r_slot] = w_keep;
        end else begin
            w_final = r_acc;
        end
    end

    // Accumulator, slot counter and registered frame outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot        <= '0;
            r_acc         <= '0;
            r_spike_vec   <= '0;
            r_first_time  <= '0;
            r_spike_count <= '0;
            r_no_spike    <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_overrun <= w_overrun;
            if (w_start) begin
                // Fresh frame: clear old bits, slot 0 taken from this cycle.
                r_acc  <= {spike_in, {(LEN - 1){1'b0}}};
                r_slot <= TW'(1);
            end else if (w_sample) begin
                r_acc  <= w_final;
                r_slot <= r_slot + TW'(1);
            end else begin
                r_acc  <= r_acc;
                r_slot <= r_slot;
            end
            if (w_load) begin
                r_spike_vec   <= w_final;
                r_first_time  <= first_index(w_final);
                r_spike_count <= pop_count(w_final);
                r_no_spike    <= ~(|w_final);
            end else begin
                r_spike_vec   <= r_spike_vec;
                r_first_time  <= r_first_time;
                r_spike_count <= r_spike_count;
                r_no_spike    <= r_no_spike;
            end
        end
    end

    assign busy            = (r_state == CAPTURE);
    assign overrun         = r_overrun;
    assign bus.out_valid   = (r_state == HOLD);
    assign bus.spike_vec   = r_spike_vec;
    assign bus.first_time  = r_first_time;
    assign bus.spike_count = r_spike_count;
    assign bus.no_spike    = r_no_spike;

endmodule

// File: tb/tb_spike_window_capture.sv
// -----------------------------------------------------------------------------
// tb_spike_window_capture
// Directed frames with literal expectations plus a randomized run, all checked
// every cycle against a frame-level model (list of spike slots per window).
// -----------------------------------------------------------------------------
module tb_spike_window_capture;
    localparam int LEN = 8;
    localparam int TW  = $clog2(LEN);
    localparam int CW  = $clog2(LEN + 1);

    logic clk         = 1'b0;
    logic rst_n       = 1'b0;
    logic frame_start = 1'b0;
    logic spike_in    = 1'b0;
    logic busy;
    logic overrun;

    spike_window_capture_if #(.LEN(LEN)) bus_if ();

    spike_window_capture #(.LEN(LEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .spike_in    (spike_in),
        .busy        (busy),
        .overrun     (overrun),
        .bus         (bus_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    bit             m_live = 1'b0;
    bit             m_capturing;
    int             m_pos;
    int             m_spikes[$];
    bit             m_valid;
    logic [0:LEN-1] m_vec;
    int             m_first;
    int             m_count;
    bit             m_nospike;
    bit             m_overrun;

    task automatic model_begin_frame();
        m_capturing = 1'b1;
        m_spikes.delete();
        m_pos = 0;
        if (spike_in) m_spikes.push_back(0);
        m_pos = 1;
    endtask

    task automatic model_publish();
        m_vec = '0;
        foreach (m_spikes[k]) m_vec[m_spikes[k]] = 1'b1;
        m_count   = m_spikes.size();
        m_first   = (m_spikes.size() > 0) ? m_spikes[0] : 0;
        m_nospike = (m_spikes.size() == 0);
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_live = 1'b1; m_capturing = 1'b0; m_valid = 1'b0; m_pos = 0;
            m_spikes.delete();
            m_vec = '0; m_first = 0; m_count = 0; m_nospike = 1'b0; m_overrun = 1'b0;
        end else if (m_live) begin
            m_overrun = 1'b0;
            if (m_capturing) begin
`ifdef FIRST_SPIKE_ONLY_EN
                if (spike_in && m_spikes.size() == 0) m_spikes.push_back(m_pos);
`else
                if (spike_in) m_spikes.push_back(m_pos);
`endif
                m_pos++;
                if (frame_start) m_overrun = 1'b1;
                if (m_pos == LEN) begin
                    m_capturing = 1'b0;
                    m_valid = 1'b1;
                    model_publish();
                end
            end else if (m_valid) begin
                if (bus_if.out_ready) begin
                    m_valid = 1'b0;
                    if (frame_start) model_begin_frame();
                end else if (frame_start) begin
                    m_overrun = 1'b1;
                end
            end else if (frame_start) begin
                model_begin_frame();
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: DUT against model on every cycle after the first reset.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            check("busy",        32'(busy),               32'(m_capturing));
            check("out_valid",   32'(bus_if.out_valid),   32'(m_valid));
            check("overrun",     32'(overrun),            32'(m_overrun));
            check("spike_vec",   32'(bus_if.spike_vec),   32'(m_vec));
            check("first_time",  32'(bus_if.first_time),  32'(m_first));
            check("spike_count", 32'(bus_if.spike_count), 32'(m_count));
            check("no_spike",    32'(bus_if.no_spike),    32'(m_nospike));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic fs, input logic sp, input logic rdy);
        frame_start      = fs;
        spike_in         = sp;
        bus_if.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [0:LEN-1] pat);
        for (int t = 0; t < LEN; t++) begin
            if (t == LEN - 1) check("lat_not_early", 32'(bus_if.out_valid), 32'd0);
            drive(t == 0, pat[t], 1'b0);
        end
        check("lat_valid", 32'(bus_if.out_valid), 32'd1);
    endtask

    task automatic accept();
        drive(1'b0, 1'b0, 1'b1);
        check("accept_drop", 32'(bus_if.out_valid), 32'd0);
    endtask

    logic [0:LEN-1] p;

    initial begin
        bus_if.out_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("rst_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_busy",  32'(busy),             32'd0);
        check("rst_vec",   32'(bus_if.spike_vec), 32'd0);
        check("rst_nosp",  32'(bus_if.no_spike),  32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0);

        // Single spike at slot 5.
        p = 8'b0000_0100;
        run_frame(p);
        check("s_vec",   32'(bus_if.spike_vec),   32'h04);
        check("s_first", 32'(bus_if.first_time),  32'd5);
        check("s_count", 32'(bus_if.spike_count), 32'd1);
        check("s_nosp",  32'(bus_if.no_spike),    32'd0);
        accept();

        // Union frame: slots 0,1,5,6.
        p = 8'b1100_0110;
        run_frame(p);
`ifdef FIRST_SPIKE_ONLY_EN
        check("u_vec",   32'(bus_if.spike_vec),   32'h80);
        check("u_count", 32'(bus_if.spike_count), 32'd1);
`else
        check("u_vec",   32'(bus_if.spike_vec),   32'hC6);
        check("u_count", 32'(bus_if.spike_count), 32'd4);
`endif
        check("u_first", 32'(bus_if.first_time), 32'd0);
        accept();

        // Empty frame.
        p = 8'b0000_0000;
        run_frame(p);
        check("e_nosp",  32'(bus_if.no_spike),    32'd1);
        check("e_first", 32'(bus_if.first_time),  32'd0);
        check("e_count", 32'(bus_if.spike_count), 32'd0);
        accept();

        // Full frame.
        p = 8'b1111_1111;
        run_frame(p);
`ifdef FIRST_SPIKE_ONLY_EN
        check("f_count", 32'(bus_if.spike_count), 32'd1);
`else
        check("f_count", 32'(bus_if.spike_count), 32'd8);
`endif
        check("f_nosp", 32'(bus_if.no_spike), 32'd0);

        // Backpressure with a dropped frame_start, then back-to-back start.
        for (int h = 0; h < 5; h++) begin
            drive(h == 2, 1'b1, 1'b0);
            check("bp_valid", 32'(bus_if.out_valid), 32'd1);
            check("bp_ovr",   32'(overrun),           (h == 2) ? 32'd1 : 32'd0);
        end
        p = 8'b0010_0000;
        drive(1'b1, p[0], 1'b1);
        for (int t = 1; t < LEN; t++) begin
            check("b2b_wait", 32'(bus_if.out_valid), 32'd0);
            drive(1'b0, p[t], 1'b0);
        end
        check("b2b_valid", 32'(bus_if.out_valid),  32'd1);
        check("b2b_first", 32'(bus_if.first_time), 32'd2);
        accept();

        // Overrun inside a capture window at slot 3.
        p = 8'b0001_1000;
        for (int t = 0; t < LEN; t++) begin
            drive((t == 0) || (t == 3), p[t], 1'b0);
            if (t == 3) check("cap_ovr",  32'(overrun), 32'd1);
            if (t == 4) check("cap_ovr0", 32'(overrun), 32'd0);
        end
        check("cap_valid", 32'(bus_if.out_valid),  32'd1);
        check("cap_first", 32'(bus_if.first_time), 32'd3);
        accept();

        // Reset mid-capture at slot 4, then a clean frame.
        for (int t = 0; t < 4; t++) drive(t == 0, 1'b1, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        check("mr_busy",  32'(busy),                 32'd0);
        check("mr_vec",   32'(bus_if.spike_vec),     32'd0);
        check("mr_count", 32'(bus_if.spike_count),   32'd0);
        for (int t = 0; t < 10; t++) drive(1'b0, 1'b1, 1'b1);
        check("mr_novalid", 32'(bus_if.out_valid), 32'd0);
        p = 8'b0000_0001;
        run_frame(p);
        check("mr_vec2",   32'(bus_if.spike_vec),   32'h01);
        check("mr_first2", 32'(bus_if.first_time),  32'd7);
        check("mr_count2", 32'(bus_if.spike_count), 32'd1);
        accept();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 7);
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
